mic_arrival_timer: RTL and testbench

//  N-channel acoustic arrival timestamp capture for the target sensor array.

---
 rtl/etarget_pkg.sv | 21 ++
 rtl/mic_arrival_timer_if.sv | 36 +++
 rtl/mic_edge_sync.sv | 70 +++++++
 rtl/mic_arrival_timer.sv | 126 ++++++++++++
 tb/tb_mic_arrival_timer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/etarget_pkg.sv
// Shared types and helpers for the microphone arrival timer.
//   fsm_t      : run-state encoding (IDLE -> RUN -> DONE)
//   MAX_CH     : largest supported channel count
//   lowest_set : index of the lowest set bit of a channel vector (0 if none)
package etarget_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int unsigned MAX_CH = 16;

    function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        // Scan downwards so the lowest set index wins.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mic_arrival_timer_if.sv
// Control/result bundle of the microphone arrival timer.
//   master : drives mic/clear/stop, observes results
//   slave  : the timer itself
//   mic       N_CH        raw comparator outputs, active high
//   clear     1           clear all results and re-arm
//   stop      1           inhibit arming/capture, freeze results
//   stamp     N_CH*CNT_W  ch k at [k*CNT_W +: CNT_W]
//   captured  N_CH        per-channel stamp-valid flags
//   first_ch  4           lowest channel that started the run
//   running   1           run in progress
//   done      1           all captured or timed out (sticky until clear)
//   timeout   1           counter saturated before all captured (sticky)
interface mic_arrival_timer_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16
);
    logic [N_CH-1:0]       mic;
    logic                  clear;
    logic                  stop;
    logic [N_CH*CNT_W-1:0] stamp;
    logic [N_CH-1:0]       captured;
    logic [3:0]            first_ch;
    logic                  running;
    logic                  done;
    logic                  timeout;

    modport master (
        output mic, clear, stop,
        input  stamp, captured, first_ch, running, done, timeout
    );

    modport slave (
        input  mic, clear, stop,
        output stamp, captured, first_ch, running, done, timeout
    );
endinterface

// File: rtl/mic_edge_sync.sv
// Per-channel input conditioning: 2-flop synchroniser, optional deglitch filter,
// registered single-cycle rise pulse.
// Config macro: MIC_DEGLITCH_EN (adds the DGL_CYC-cycle high-time qualifier).
//   clk64M  in   system clock
//   reset_n in   async active-low reset
//   mic_raw in   asynchronous comparator output
//   rise    out  one-cycle pulse, 3 cycles (3+DGL_CYC-1 with filter) after raw rise
module mic_edge_sync
`ifdef MIC_DEGLITCH_EN
#(
    parameter int unsigned DGL_CYC = 4
)
`endif
(
    input  logic clk64M,
    input  logic reset_n,
    input  logic mic_raw,
    output logic rise
);

    logic sync1_q, sync2_q, rise_q;

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mic_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef MIC_DEGLITCH_EN
    // Count consecutive high cycles, saturating one past the threshold so the
    // pulse fires exactly once per qualified high period.
    logic [3:0] hcnt_q;
    logic       hit;

    assign hit = sync2_q && (hcnt_q == 4'(DGL_CYC - 1));

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            rise_q <= 1'b0;
        end else begin
            if (!sync2_q) begin
                hcnt_q <= '0;
            end else if (hcnt_q != 4'(DGL_CYC)) begin
                hcnt_q <= hcnt_q + 4'd1;
            end
            rise_q <= hit;
        end
    end
`else
    logic sync3_q;

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
        end
    end
`endif

    assign rise = rise_q;

endmodule

// File: rtl/mic_arrival_timer.sv
// N-channel acoustic arrival timestamp capture. The first recognised rise starts
// a shared counter; every channel latches the count at its own first rise.
// Config macro: MIC_DEGLITCH_EN (enables DGL_CYC input filter in every channel).
//   clk64M  in   64 MHz system clock
//   reset_n in   async active-low reset
//   bus     slave modport of mic_arrival_timer_if (mic/clear/stop in, results out)
module mic_arrival_timer
    import etarget_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
`ifdef MIC_DEGLITCH_EN
    parameter int unsigned DGL_CYC = 4,
`endif
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk64M,
    input  logic                 reset_n,
    mic_arrival_timer_if.slave   bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] rise;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        mic_edge_sync
`ifdef MIC_DEGLITCH_EN
        #(.DGL_CYC(DGL_CYC))
`endif
        u_sync (
            .clk64M (clk64M),
            .reset_n(reset_n),
            .mic_raw(bus.mic[k]),
            .rise   (rise[k])
        );
    end

    fsm_t                       state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc, stamp_val;
    logic [N_CH-1:0][CNT_W-1:0] stamp_q, stamp_d;
    logic [N_CH-1:0]            captured_q, captured_d, take;
    logic [3:0]                 first_ch_q, first_ch_d;
    logic                       timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stamp_d    = stamp_q;
        captured_d = captured_q;
        first_ch_d = first_ch_q;
        timeout_d  = timeout_q;
        take       = '0;
        // cnt never exceeds CntMax-1 while in RUN, so this cannot wrap there.
        cnt_inc    = cnt_q + CntOne;
        // The starting rise reads 0; later rises read the count after this edge.
        stamp_val  = (state_q == IDLE) ? '0 : cnt_inc;

        if (bus.clear) begin
            state_d    = IDLE;
            cnt_d      = '0;
            stamp_d    = '0;
            captured_d = '0;
            first_ch_d = '0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!bus.stop && (|rise)) begin
                        take       = rise;
                        first_ch_d = lowest_set(MAX_CH'(rise));
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_inc;
                    if (!bus.stop) take = rise & ~captured_q;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase

            for (int k = 0; k < N_CH; k++) begin
                if (take[k]) stamp_d[k] = stamp_val;
            end
            captured_d = captured_q | take;

            // Completion beats saturation when both land in the same cycle.
            if (state_d == RUN) begin
                if (&captured_d) begin
                    state_d = DONE;
                end else if (cnt_d == CntMax) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stamp_q    <= '0;
            captured_q <= '0;
            first_ch_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stamp_q    <= stamp_d;
            captured_q <= captured_d;
            first_ch_q <= first_ch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.stamp    = stamp_q;
    assign bus.captured = captured_q;
    assign bus.first_ch = first_ch_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mic_arrival_timer.sv
// Self-checking bench for mic_arrival_timer: directed scenarios plus randomised
// arrival patterns compared against an arrival-offset model.
module tb_mic_arrival_timer;

    localparam int N = 4;
    localparam int W = 16;

    logic clk64M = 1'b0;
    logic reset_n;

    always #5 clk64M = ~clk64M;

    mic_arrival_timer_if #(.N_CH(N), .CNT_W(W)) bus ();
    mic_arrival_timer_if #(.N_CH(N), .CNT_W(8)) bus8 ();

    mic_arrival_timer #(.N_CH(N), .CNT_W(W)) dut (
        .clk64M (clk64M),
        .reset_n(reset_n),
        .bus    (bus)
    );

    mic_arrival_timer #(.N_CH(N), .CNT_W(8)) dut8 (
        .clk64M (clk64M),
        .reset_n(reset_n),
        .bus    (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk64M);
        #1;
    endtask

    task automatic clear_pulse();
        bus.clear  = 1'b1;
        bus8.clear = 1'b1;
        step();
        bus.clear  = 1'b0;
        bus8.clear = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bus.mic = '0;  bus.clear = 1'b0;  bus.stop = 1'b0;
        bus8.mic = '0; bus8.clear = 1'b0; bus8.stop = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.stamp !== '0 || bus.captured !== '0 || bus.first_ch !== 4'd0 ||
            bus.running !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stamp=%h cap=%b first=%0d run=%b done=%b to=%b, want all 0",
                     bus.stamp, bus.captured, bus.first_ch, bus.running, bus.done, bus.timeout);
        end
        bad = 0;
        repeat (1000) begin
            step();
            if (bus.running !== 1'b0 || bus.captured !== '0 || bus.done !== 1'b0 ||
                bus.stamp !== '0 || bus8.running !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_1000: %0d cycles with activity, want 0", bad);
        end
    endtask

    // Model: a channel arriving at offset off[k] reads off[k]-min(off); the run is
    // started by the lowest index among the earliest arrivals.
    task automatic run_case(input string name, input int off[N]);
        int mn, mx, fc, waited;
        int exp_stamp[N];
        mn = off[0]; mx = off[0]; fc = 0;
        for (int k = 1; k < N; k++) begin
            if (off[k] < mn) begin mn = off[k]; fc = k; end
            if (off[k] > mx) mx = off[k];
        end
        for (int k = 0; k < N; k++) exp_stamp[k] = off[k] - mn;

        bus.mic = '0;
        for (int c = 0; c <= mx; c++) begin
            for (int k = 0; k < N; k++) if (off[k] == c) bus.mic[k] = 1'b1;
            step();
        end
        waited = 0;
        while (bus.done !== 1'b1 && waited < 30) begin
            step();
            waited++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b timeout=%b running=%b, want 1/0/0",
                     name, bus.done, bus.timeout, bus.running);
        end
        checks++;
        if (bus.captured !== 4'hF) begin
            errors++;
            $display("FAIL %s_captured: got %b want 1111", name, bus.captured);
        end
        checks++;
        if (bus.first_ch !== 4'(fc)) begin
            errors++;
            $display("FAIL %s_first_ch: got %0d want %0d", name, bus.first_ch, fc);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (bus.stamp[k*W +: W] !== W'(exp_stamp[k])) begin
                errors++;
                $display("FAIL %s_stamp%0d: got %0d want %0d",
                         name, k, bus.stamp[k*W +: W], exp_stamp[k]);
            end
        end
        bus.mic = '0;
        repeat (6) step();
        clear_pulse();
        checks++;
        if (bus.captured !== '0 || bus.done !== 1'b0 || bus.stamp !== '0 ||
            bus.first_ch !== 4'd0) begin
            errors++;
            $display("FAIL %s_cleared: cap=%b done=%b stamp=%h first=%0d, want 0",
                     name, bus.captured, bus.done, bus.stamp, bus.first_ch);
        end
    endtask

    task automatic test_sequence();
        int o[N];
        o = '{0, 64, 128, 192};
        run_case("seq", o);
    endtask

    task automatic test_simultaneous();
        int o[N];
        o = '{40, 100, 0, 0};
        run_case("simul", o);
    endtask

    task automatic test_random();
        int o[N];
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N; k++) o[k] = int'($urandom_range(0, 60));
            run_case($sformatf("rand%0d", it), o);
        end
    endtask

    task automatic test_timeout();
        int waited;
        bus8.mic = 4'b0010;
        waited = 0;
        while (bus8.captured !== 4'b0010 && waited < 20) begin
            step();
            waited++;
        end
        waited = 0;
        while (bus8.done !== 1'b1 && waited < 400) begin
            step();
            waited++;
        end
        checks++;
        if (waited !== 255) begin
            errors++;
            $display("FAIL to_latency: done after %0d cycles, want 255", waited);
        end
        checks++;
        if (bus8.timeout !== 1'b1 || bus8.done !== 1'b1 || bus8.running !== 1'b0) begin
            errors++;
            $display("FAIL to_flags: timeout=%b done=%b running=%b, want 1/1/0",
                     bus8.timeout, bus8.done, bus8.running);
        end
        checks++;
        if (bus8.captured !== 4'b0010 || bus8.first_ch !== 4'd1 ||
            bus8.stamp[8 +: 8] !== 8'd0) begin
            errors++;
            $display("FAIL to_result: cap=%b first=%0d stamp1=%0d, want 0010/1/0",
                     bus8.captured, bus8.first_ch, bus8.stamp[8 +: 8]);
        end
        repeat (20) step();
        checks++;
        if (dut8.cnt_q !== 8'd255 || bus8.done !== 1'b1) begin
            errors++;
            $display("FAIL to_hold: cnt=%0d done=%b, want 255/1", dut8.cnt_q, bus8.done);
        end
        bus8.mic = '0;
        repeat (6) step();
        clear_pulse();
        checks++;
        if (bus8.timeout !== 1'b0 || bus8.done !== 1'b0 || dut8.cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL to_cleared: timeout=%b done=%b cnt=%0d, want 0/0/0",
                     bus8.timeout, bus8.done, dut8.cnt_q);
        end
    endtask

    task automatic test_clear();
        bus.mic = 4'b0001;
        repeat (12) step();
        checks++;
        if (bus.running !== 1'b1 || bus.captured !== 4'b0001) begin
            errors++;
            $display("FAIL clr_pre: running=%b cap=%b, want 1/0001", bus.running, bus.captured);
        end
        clear_pulse();
        checks++;
        if (bus.stamp !== '0 || bus.captured !== '0 || bus.first_ch !== 4'd0 ||
            bus.running !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL clr_outputs: stamp=%h cap=%b first=%0d run=%b done=%b to=%b, want 0",
                     bus.stamp, bus.captured, bus.first_ch, bus.running, bus.done, bus.timeout);
        end
        // ch0 stays high so only the fresh ch3 rise may start the new run.
        bus.mic = 4'b1001;
        repeat (10) step();
        checks++;
        if (bus.running !== 1'b1 || bus.first_ch !== 4'd3 || bus.captured !== 4'b1000 ||
            bus.stamp[3*W +: W] !== W'(0)) begin
            errors++;
            $display("FAIL clr_restart: run=%b first=%0d cap=%b stamp3=%0d, want 1/3/1000/0",
                     bus.running, bus.first_ch, bus.captured, bus.stamp[3*W +: W]);
        end
        bus.mic = '0;
        repeat (6) step();
        // Held clear keeps the block idle through a rise.
        bus.clear = 1'b1;
        bus.mic   = 4'b0100;
        repeat (10) step();
        bus.clear = 1'b0;
        repeat (10) step();
        checks++;
        if (bus.running !== 1'b0 || bus.captured !== '0) begin
            errors++;
            $display("FAIL clr_held: running=%b cap=%b, want 0/0000", bus.running, bus.captured);
        end
        bus.mic = '0;
        repeat (6) step();
    endtask

    task automatic test_stop();
        bus.stop = 1'b1;
        bus.mic  = 4'b0101;
        repeat (6) step();
        bus.mic = '0;
        repeat (8) step();
        bus.stop = 1'b0;
        repeat (6) step();
        checks++;
        if (bus.running !== 1'b0 || bus.captured !== '0) begin
            errors++;
            $display("FAIL stop_idle: running=%b cap=%b, want 0/0000", bus.running, bus.captured);
        end
        bus.mic = 4'b0001;
        repeat (8) step();
        bus.stop = 1'b1;
        bus.mic  = 4'b0011;
        repeat (6) step();
        bus.mic = 4'b0001;
        repeat (8) step();
        checks++;
        if (bus.running !== 1'b1 || bus.captured !== 4'b0001) begin
            errors++;
            $display("FAIL stop_run: running=%b cap=%b, want 1/0001", bus.running, bus.captured);
        end
        bus.stop = 1'b0;
        bus.mic  = '0;
        repeat (6) step();
        clear_pulse();
    endtask

    task automatic test_async_reset();
        bus.mic = 4'b0010;
        repeat (15) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.running !== 1'b0 || bus.captured !== '0 || bus.stamp !== '0 ||
            bus.first_ch !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: run=%b cap=%b stamp=%h first=%0d, want 0",
                     bus.running, bus.captured, bus.stamp, bus.first_ch);
        end
        bus.mic = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (10) step();
        checks++;
        if (bus.running !== 1'b0 || bus.captured !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: running=%b cap=%b, want 0/0000",
                     bus.running, bus.captured);
        end
    endtask

`ifdef MIC_DEGLITCH_EN
    task automatic test_deglitch();
        bus.mic = 4'b0001;
        repeat (3) step();
        bus.mic = '0;
        repeat (15) step();
        checks++;
        if (bus.captured !== '0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL dgl_short: cap=%b running=%b, want 0000/0", bus.captured, bus.running);
        end
        bus.mic = 4'b0001;
        repeat (4) step();
        bus.mic = '0;
        repeat (15) step();
        checks++;
        if (bus.captured !== 4'b0001 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL dgl_long: cap=%b running=%b, want 0001/1", bus.captured, bus.running);
        end
        clear_pulse();
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_simultaneous();
        test_random();
        test_timeout();
        test_clear();
        test_stop();
        test_async_reset();
`ifdef MIC_DEGLITCH_EN
        test_deglitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
